residual_decoder_4x4: RTL and testbench
=======================================

Name: residual_decoder_4x4

Overview:
- Decoder-side residual reconstruction for 4x4 luma blocks. It is the inverse path fed by the entropy decoder.
- Accepts 16 quantized levels serially in zigzag scan order over a valid/ready handshake.
- Performs inverse zigzag, H.264 dequantization (level·V·2^(QP/6)), 2-D inverse integer transform with (x+32)>>6 rounding, and saturation.
- Presents the 16 signed 8-bit residuals in parallel to the reconstruction adder, also over valid/ready.

Parameters:
- BIT_LENGTH, 31, MSB index of internal signed datapath (internal width BIT_LENGTH+1).
- COEF_W, 16, width of signed input level.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- QP, input, 6, quantization parameter; sampled on the first accepted coefficient of a block.
- in_valid, input, 1, in_coef holds a valid level.
- in_ready, output, 1, block can accept a level.
- in_coef, input, COEF_W, signed quantized level in zigzag order.
- out_valid, output, 1, residuals valid.
- out_ready, input, 1, consumer takes residuals.
- residuals, output, 16 x 8 (signed [7:0] [15:0]), reconstructed residuals; index = row*4+col.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, cnt=0, coefficient buffer cleared, residuals all 0, out_valid=0.
  - in_ready=0 while reset is high.
- States: IDLE, LOAD, DEQ, ROW, COL, OUT.
- in_ready=1 only in IDLE and LOAD. A transfer occurs on in_valid&&in_ready.
- IDLE:
  - On a transfer: latch QP, clamped to 51 if QP>51.
  - Write in_coef to raster slot ZZ[0]. Set cnt=1 and go to LOAD.
- LOAD:
  - Each transfer writes raster slot ZZ[cnt] and increments cnt.
  - The transfer with cnt==15 goes to DEQ.
  - Cycles with in_valid low are gaps and have no effect.
- ZZ (scan index to raster index): 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- QP decomposition:
  - qp_div6 = QPlatched/6 (0..8), qp_mod6 = QPlatched%6.
  - Both are derived from the latched value and registered by the end of LOAD.
- DEQ (1 cycle): every slot becomes sign-extended level * V[qp_mod6][class] << qp_div6, at BIT_LENGTH+1 bits.
  - class 0: (row,col) both even.
  - class 1: both odd.
  - class 2: otherwise.
  - V rows for mod 0..5, listed as {c0,c1,c2}: {10,16,13}, {11,18,14}, {13,20,16}, {14,23,18}, {16,25,20}, {18,29,23}.
- ROW (1 cycle): 1-D inverse transform on each row a0..a3.
  - e=a0+a2, f=a0-a2, g=(a1>>>1)-a3, h=a1+(a3>>>1).
  - Outputs: e+h, f+g, f-g, e-h.
- COL (1 cycle):
  - Apply the same transform on each column.
  - Then y=(x+32)>>>6 (arithmetic, floor).
  - Saturate to [-128,127] and register into residuals.
  - Go to OUT.
- OUT:
  - out_valid=1.
  - residuals, out_valid and busy hold stable until out_ready.
  - On out_valid&&out_ready: out_valid=0 next cycle, state IDLE.
  - in_valid is ignored in this state.
- Latency: out_valid rises exactly 3 cycles after the clock edge accepting the 16th level. Throughput is one block per 16+3+1 cycles minimum.
- No overlap: the next block cannot start until residuals are consumed.
- QP changes after the first transfer have no effect on the current block.
- Intermediate arithmetic never wraps for |level|≤2^15 at BIT_LENGTH=31.

Test Plan:
1. DC test. Inputs: QP=28, level 1 at scan 0, other 15 levels 0, out_ready=1. Required response: all 16 residuals = 4 (256+32>>6), out_valid 3 cycles after last accept and high for 1 cycle.
2. Zigzag test. Inputs: QP=28, level 1 at scan index 1 only. Required response: every row = [5,3,-2,-5], which confirms raster slot 1 and class 2 (V=20).
3. Saturation test. Inputs: QP=51, DC level +100. Required response: all residuals 127. Repeat with DC level -100: all residuals -128. Repeat with QP=63: results identical to QP=51.
4. Backpressure test. Hold out_ready=0 for 10 cycles after out_valid while toggling in_valid. Required response: residuals stable, in_ready=0, no level consumed. On release: IDLE next cycle with in_ready=1.
5. Input gaps test. Drive test 2 with in_valid low on alternate cycles and QP changed to 0 mid-block. Required response: identical result to test 2, with out_valid 3 cycles after the 16th accept.
6. Reset test. Assert reset after 7 levels accepted. Required response: immediately busy=0, out_valid=0, residuals 0. After release, a fresh test 1 block gives all 4s.

Source files
------------

// File: rtl/residual_decoder_4x4.sv
// Residual decoder for 4x4 luma blocks: collects 16 zigzag-ordered levels,
// dequantizes them, runs the 2-D inverse integer transform, rounds and
// saturates to signed 8-bit residuals.
//
// Handshake: a level moves on every rising edge where in_valid && in_ready;
// a residual block moves on every rising edge where out_valid && out_ready.
// The producer holds in_coef while in_valid is high and the block is not
// ready. The block holds residuals stable while out_valid is high and
// out_ready is low.
module residual_decoder_4x4 #(
    parameter int BIT_LENGTH = 31,
    parameter int COEF_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [5:0]               QP,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [7:0]        residuals [16],
    output logic                     busy
);
    localparam int W = BIT_LENGTH + 1;
    localparam logic signed [W-1:0] RND    = 32;
    localparam logic signed [W-1:0] SAT_HI = 127;
    localparam logic signed [W-1:0] SAT_LO = -128;

    typedef enum logic [2:0] {IDLE, LOAD, DEQ, ROW, COL, OUT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q;
    logic [5:0]          qp_q;
    logic [3:0]          qp_div6_q;
    logic [2:0]          qp_mod6_q;
    logic signed [W-1:0] coef_q  [16];
    logic signed [W-1:0] deq_val [16];
    logic signed [W-1:0] row_val [16];
    logic signed [7:0]   col_val [16];
    logic [4*W-1:0]      row_tmp, col_tmp;
    logic                xfer_in, xfer_out;

    // Scan position to raster position (row*4+col).
    function automatic logic [3:0] zz_pos(input logic [3:0] s);
        case (s)
            4'd0:  return 4'd0;
            4'd1:  return 4'd1;
            4'd2:  return 4'd4;
            4'd3:  return 4'd8;
            4'd4:  return 4'd5;
            4'd5:  return 4'd2;
            4'd6:  return 4'd3;
            4'd7:  return 4'd6;
            4'd8:  return 4'd9;
            4'd9:  return 4'd12;
            4'd10: return 4'd13;
            4'd11: return 4'd10;
            4'd12: return 4'd7;
            4'd13: return 4'd11;
            4'd14: return 4'd14;
            default: return 4'd15;
        endcase
    endfunction

    // Position class: 0 = row and col even, 1 = both odd, 2 = mixed.
    function automatic logic [1:0] pos_class(input logic [3:0] idx);
        if (!idx[2] && !idx[0]) return 2'd0;
        if (idx[2] && idx[0])   return 2'd1;
        return 2'd2;
    endfunction

    // Dequantization scale V[qp%6][class].
    function automatic logic [4:0] v_coef(input logic [2:0] m, input logic [1:0] c);
        logic [4:0] v0, v1, v2;
        case (m)
            3'd1:    begin v0 = 5'd11; v1 = 5'd18; v2 = 5'd14; end
            3'd2:    begin v0 = 5'd13; v1 = 5'd20; v2 = 5'd16; end
            3'd3:    begin v0 = 5'd14; v1 = 5'd23; v2 = 5'd18; end
            3'd4:    begin v0 = 5'd16; v1 = 5'd25; v2 = 5'd20; end
            3'd5:    begin v0 = 5'd18; v1 = 5'd29; v2 = 5'd23; end
            default: begin v0 = 5'd10; v1 = 5'd16; v2 = 5'd13; end
        endcase
        case (c)
            2'd0:    return v0;
            2'd1:    return v1;
            default: return v2;
        endcase
    endfunction

    // 1-D inverse integer transform; output k sits at bits [k*W +: W].
    function automatic logic [4*W-1:0] itx(input logic signed [W-1:0] a0, input logic signed [W-1:0] a1,
                                            input logic signed [W-1:0] a2, input logic signed [W-1:0] a3);
        logic signed [W-1:0] e, f, g, h;
        e = a0 + a2;
        f = a0 - a2;
        g = (a1 >>> 1) - a3;
        h = a1 + (a3 >>> 1);
        return {e - h, f - g, f + g, e + h};
    endfunction

    // Round by (x+32)>>6 with floor semantics, then clamp to signed 8 bits.
    function automatic logic signed [7:0] sat8(input logic signed [W-1:0] x);
        logic signed [W-1:0] t;
        t = (x + RND) >>> 6;
        if (t > SAT_HI) return 8'sd127;
        if (t < SAT_LO) return -8'sd128;
        return t[7:0];
    endfunction

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                in_ready = !reset;
                if (xfer_in) state_d = LOAD;
            end
            LOAD: begin
                in_ready = !reset;
                if (xfer_in && cnt_q == 4'd15) state_d = DEQ;
            end
            DEQ: state_d = ROW;
            ROW: state_d = COL;
            COL: state_d = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (xfer_out) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arithmetic for the DEQ, ROW and COL steps, all computed from the buffer.
    always_comb begin
        row_tmp = '0;
        col_tmp = '0;
        for (int i = 0; i < 16; i++) begin
            deq_val[i] = (coef_q[i] * $signed({{(W-5){1'b0}}, v_coef(qp_mod6_q, pos_class(4'(i)))}))
                         <<< qp_div6_q;
            row_val[i] = '0;
            col_val[i] = '0;
        end
        for (int r = 0; r < 4; r++) begin
            row_tmp = itx(coef_q[r*4], coef_q[r*4+1], coef_q[r*4+2], coef_q[r*4+3]);
            for (int k = 0; k < 4; k++) row_val[r*4+k] = $signed(row_tmp[k*W +: W]);
        end
        for (int c = 0; c < 4; c++) begin
            col_tmp = itx(coef_q[c], coef_q[4+c], coef_q[8+c], coef_q[12+c]);
            for (int k = 0; k < 4; k++) col_val[k*4+c] = sat8($signed(col_tmp[k*W +: W]));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Coefficient buffer, QP capture and residual output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            qp_q      <= '0;
            qp_div6_q <= '0;
            qp_mod6_q <= '0;
            for (int i = 0; i < 16; i++) begin
                coef_q[i]    <= '0;
                residuals[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: if (xfer_in) begin
                    qp_q <= (QP > 6'd51) ? 6'd51 : QP;
                    coef_q[zz_pos(4'd0)] <= {{(W-COEF_W){in_coef[COEF_W-1]}}, in_coef};
                    cnt_q <= 4'd1;
                end
                LOAD: begin
                    // QP split is settled long before DEQ since LOAD lasts >= 15 cycles.
                    qp_div6_q <= 4'(qp_q / 6'd6);
                    qp_mod6_q <= 3'(qp_q % 6'd6);
                    if (xfer_in) begin
                        coef_q[zz_pos(cnt_q)] <= {{(W-COEF_W){in_coef[COEF_W-1]}}, in_coef};
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DEQ: for (int i = 0; i < 16; i++) coef_q[i] <= deq_val[i];
                ROW: for (int i = 0; i < 16; i++) coef_q[i] <= row_val[i];
                COL: for (int i = 0; i < 16; i++) residuals[i] <= col_val[i];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_residual_decoder_4x4.sv
// Bench for residual_decoder_4x4: directed blocks plus randomized blocks,
// checked against a matrix-form reference model through an expected queue.
module tb_residual_decoder_4x4;
    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        QP;
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] in_coef;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] residuals [16];
    logic              busy;

    residual_decoder_4x4 #(.BIT_LENGTH(31), .COEF_W(16)) dut (
        .clk(clk), .reset(reset), .QP(QP), .in_valid(in_valid), .in_ready(in_ready),
        .in_coef(in_coef), .out_valid(out_valid), .out_ready(out_ready),
        .residuals(residuals), .busy(busy)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    int last_accept_cyc = 0;
    logic ov_prev = 1'b0;
    logic [127:0] exp_q[$];
    int blk_lv [16];

    int zz_tab [16]   = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    int v_tab  [6][3] = '{'{10, 16, 13}, '{11, 18, 14}, '{13, 20, 16},
                          '{14, 23, 18}, '{16, 25, 20}, '{18, 29, 23}};
    // Inverse transform matrix: 2 = +a, -2 = -a, 1 = +floor(a/2), -1 = -floor(a/2).
    int t_tab  [4][4] = '{'{2, 2, 2, 1}, '{2, 1, -2, -2}, '{2, -1, -2, 2}, '{2, -2, 2, -1}};

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] pack_res();
        logic [127:0] p;
        for (int k = 0; k < 16; k++) p[k*8 +: 8] = residuals[k];
        return p;
    endfunction

    function automatic int term(input int c, input int a);
        case (c)
            2:       return a;
            -2:      return -a;
            1:       return a >>> 1;
            default: return -(a >>> 1);
        endcase
    endfunction

    // Reference: scatter, scale, then transform rows and columns as matrix products.
    function automatic logic [127:0] ref_model(input int qp_in);
        int q, r, rw, cl, cls, u, y;
        int d [16];
        int t [16];
        logic [127:0] p;
        q = (qp_in > 51) ? 51 : qp_in;
        for (int s = 0; s < 16; s++) begin
            r  = zz_tab[s];
            rw = r / 4;
            cl = r % 4;
            if (rw % 2 == 0 && cl % 2 == 0)      cls = 0;
            else if (rw % 2 == 1 && cl % 2 == 1) cls = 1;
            else                                 cls = 2;
            d[r] = blk_lv[s] * v_tab[q % 6][cls] * (1 << (q / 6));
        end
        for (int row = 0; row < 4; row++)
            for (int k = 0; k < 4; k++) begin
                t[row*4+k] = 0;
                for (int j = 0; j < 4; j++) t[row*4+k] += term(t_tab[k][j], d[row*4+j]);
            end
        p = '0;
        for (int col = 0; col < 4; col++)
            for (int k = 0; k < 4; k++) begin
                u = 0;
                for (int j = 0; j < 4; j++) u += term(t_tab[k][j], t[j*4+col]);
                y = (u + 32) >>> 6;
                if (y > 127)  y = 127;
                if (y < -128) y = -128;
                p[(k*4+col)*8 +: 8] = 8'(y);
            end
        return p;
    endfunction

    // Monitor: latency on each out_valid rise, scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !ov_prev)
                check_eq("latency", 128'(cyc), 128'(last_accept_cyc + 3));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %h with no block pending", pack_res());
                end else begin
                    check_eq("residuals", pack_res(), exp_q.pop_front());
                end
            end
        end
        ov_prev = out_valid;
    end

    // Driver: one level, waits (bounded) for in_ready.
    task automatic send_level(input int lv);
        logic got;
        got = 1'b0;
        in_coef  = 16'(lv);
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready 0 for 100 cycles, required 1");
        end
        @(posedge clk); #1;
        last_accept_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic load_block(input int qp, input bit gaps, input bit chg, input int new_qp);
        exp_q.push_back(ref_model(qp));
        QP = 6'(qp);
        for (int s = 0; s < 16; s++) begin
            send_level(blk_lv[s]);
            if (s == 0 && chg) QP = 6'(new_qp);
            if (gaps && s < 15) begin
                in_coef = 16'($urandom);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_valid();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (out_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL out_valid_timeout: out_valid 0 for 20 cycles, required 1");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("out_valid_drop", out_valid, 1'b0);
        check_eq("idle_in_ready", in_ready, 1'b1);
        check_eq("idle_busy", busy, 1'b0);
    endtask

    task automatic run_block(input int qp, input bit gaps, input bit chg, input int new_qp, input int hold);
        out_ready = (hold == 0);
        load_block(qp, gaps, chg, new_qp);
        wait_valid();
        repeat (hold) begin @(posedge clk); #1; end
        drain();
    endtask

    task automatic set_single(input int scan, input int lv);
        for (int s = 0; s < 16; s++) blk_lv[s] = 0;
        blk_lv[scan] = lv;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Main sequence.
    initial begin
        reset = 1'b1; QP = '0; in_valid = 1'b0; in_coef = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_residuals", pack_res(), 128'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // DC block
        set_single(0, 1);
        run_block(28, 1'b0, 1'b0, 0, 0);
        check_eq("dc_known", pack_res(), {16{8'h04}});

        // Single AC level at scan 1
        set_single(1, 1);
        run_block(28, 1'b0, 1'b0, 0, 0);
        check_eq("zigzag_known", pack_res(), {4{32'hFBFE0305}});

        // Saturation, and QP above 51 behaving as 51
        set_single(0, 100);
        run_block(51, 1'b0, 1'b0, 0, 0);
        check_eq("sat_pos", pack_res(), {16{8'h7F}});
        set_single(0, -100);
        run_block(51, 1'b0, 1'b0, 0, 0);
        check_eq("sat_neg", pack_res(), {16{8'h80}});
        set_single(0, 1);
        blk_lv[3] = -2;
        blk_lv[8] = 1;
        run_block(63, 1'b0, 1'b0, 0, 0);
        run_block(51, 1'b0, 1'b0, 0, 0);

        // Backpressure with in_valid toggling during OUT
        set_single(1, 1);
        out_ready = 1'b0;
        load_block(28, 1'b0, 1'b0, 0);
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            in_valid = (k % 2 == 0);
            in_coef  = 16'($urandom);
            @(negedge clk);
            check_eq("bp_in_ready", in_ready, 1'b0);
            check_eq("bp_out_valid", out_valid, 1'b1);
            check_eq("bp_busy", busy, 1'b1);
            if (exp_q.size() > 0) check_eq("bp_residuals", pack_res(), exp_q[0]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        set_single(0, 1);
        run_block(28, 1'b0, 1'b0, 0, 0);
        check_eq("after_bp_dc", pack_res(), {16{8'h04}});

        // Input gaps and mid-block QP change
        set_single(1, 1);
        run_block(28, 1'b1, 1'b1, 0, 0);
        check_eq("gaps_known", pack_res(), {4{32'hFBFE0305}});

        // Reset in the middle of a block
        set_single(0, 1);
        QP = 6'd28;
        for (int s = 0; s < 7; s++) send_level(blk_lv[s]);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_in_ready", in_ready, 1'b0);
        check_eq("mid_rst_residuals", pack_res(), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_block(28, 1'b0, 1'b0, 0, 0);
        check_eq("post_rst_dc", pack_res(), {16{8'h04}});

        // Randomized blocks
        for (int b = 0; b < 25; b++) begin
            for (int s = 0; s < 16; s++) begin
                int m;
                m = int'($urandom_range(0, 9));
                if (m < 5)      blk_lv[s] = 0;
                else if (m < 9) blk_lv[s] = int'($urandom_range(0, 40)) - 20;
                else            blk_lv[s] = int'($urandom_range(0, 4000)) - 2000;
            end
            run_block(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
        end

        repeat (5) @(posedge clk);
        #1;
        check_eq("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
